// File: rtl/sdi_trs_decoder.sv
// BT.656 timing-reference detector for the SDI-to-MIPI bridge front end.
// Regenerates H/V/F/DE flags aligned with a 4-cycle delayed byte stream and tracks line-length lock.
module sdi_trs_decoder #(
  parameter int unsigned LOCK_LINES = 4
) (
  input  logic       sys_clk,
  input  logic       n_rst,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       hsync_o,
  output logic       vsync_o,
  output logic       field_o,
  output logic       de_o,
  output logic       trs_err_o,
  output logic       locked_o
);

  localparam logic [3:0] LOCK_TARGET = 4'(LOCK_LINES);

  typedef enum logic [1:0] {
    HUNT,
    CHECK,
    LOCKED
  } lock_state_t;

  logic [7:0]  h2, h1, h0;
  logic        xy_f, xy_v, xy_h;
  logic        xy_ok;
  logic        trs_hit, eav_hit, sav_hit, err_hit;

  logic [3:0]  sav_pend;
  logic [3:0]  sav_vb;

  logic [15:0] line_cnt;
  logic [15:0] ref_len;
  logic        line_sat;
  logic        len_mismatch;

  lock_state_t state;
  logic [3:0]  good;
  logic [3:0]  good_inc;
  logic        has_ref;

  // ---------------------------------------------------------------------------
  // TRS detection: FF 00 00 in history plus a current byte with bit 7 set.
  // ---------------------------------------------------------------------------
  assign xy_f = data_i[6];
  assign xy_v = data_i[5];
  assign xy_h = data_i[4];

  assign xy_ok = (data_i[3] == (xy_v ^ xy_h)) &&
                 (data_i[2] == (xy_f ^ xy_h)) &&
                 (data_i[1] == (xy_f ^ xy_v)) &&
                 (data_i[0] == (xy_f ^ xy_v ^ xy_h));

  assign trs_hit = (h2 == 8'hFF) && (h1 == 8'h00) && (h0 == 8'h00) && data_i[7];
  assign eav_hit = trs_hit && xy_ok && xy_h;
  assign sav_hit = trs_hit && xy_ok && !xy_h;
  assign err_hit = trs_hit && !xy_ok;

  // History doubles as the first three stages of the data_o delay line.
  // NOTE: sequential state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour regardless of statement order.
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      h0     <= 8'h00;
      h1     <= 8'h00;
      h2     <= 8'h00;
      data_o <= 8'h00;
    end else begin
      h0     <= data_i;
      h1     <= h0;
      h2     <= h1;
      data_o <= h2;
    end
  end

  // ---------------------------------------------------------------------------
  // Flag regeneration. An EAV's FF byte reaches data_o one cycle after its XY,
  // so EAV flags update immediately; a SAV's first active byte trails its XY by
  // five cycles, so the SAV event is carried through a 4-deep delay.
  // ---------------------------------------------------------------------------
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      sav_pend <= 4'b0000;
      sav_vb   <= 4'b0000;
    end else begin
      sav_pend <= {sav_pend[2:0], sav_hit};
      sav_vb   <= {sav_vb[2:0], xy_v};
    end
  end

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      hsync_o   <= 1'b0;
      vsync_o   <= 1'b0;
      field_o   <= 1'b0;
      de_o      <= 1'b0;
      trs_err_o <= 1'b0;
    end else begin
      trs_err_o <= err_hit;
      if (eav_hit) begin
        hsync_o <= 1'b1;
        de_o    <= 1'b0;
        vsync_o <= xy_v;
        field_o <= xy_f;
      end else if (sav_pend[3]) begin
        hsync_o <= 1'b0;
        de_o    <= ~sav_vb[3];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Line-length measurement: restarts at 1 on each EAV XY, so an EAV-to-EAV
  // distance of L bytes reads L at the next EAV. A saturated count never matches.
  // ---------------------------------------------------------------------------
  assign line_sat     = (line_cnt == 16'hFFFF);
  assign len_mismatch = line_sat || (line_cnt != ref_len);
  assign good_inc     = good + 4'd1;

  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      line_cnt <= 16'h0000;
    end else if (eav_hit) begin
      line_cnt <= 16'h0001;
    end else if (!line_sat) begin
      line_cnt <= line_cnt + 16'h0001;
    end
  end

  // Lock FSM; a protection error overrides any EAV decision in the same cycle.
  always_ff @(posedge sys_clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= HUNT;
      good     <= 4'd0;
      ref_len  <= 16'h0000;
      has_ref  <= 1'b0;
      locked_o <= 1'b0;
    end else if (err_hit) begin
      state    <= HUNT;
      locked_o <= 1'b0;
    end else if (eav_hit) begin
      case (state)
        HUNT: begin
          state    <= CHECK;
          good     <= 4'd0;
          has_ref  <= 1'b0;
          locked_o <= 1'b0;
        end
        CHECK: begin
          if (!has_ref || len_mismatch) begin
            ref_len <= line_cnt;
            has_ref <= 1'b1;
            good    <= 4'd1;
            if (LOCK_TARGET == 4'd1) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end
          end else begin
            good <= good_inc;
            if (good_inc == LOCK_TARGET) begin
              state    <= LOCKED;
              locked_o <= 1'b1;
            end
          end
        end
        LOCKED: begin
          if (len_mismatch) begin
            state    <= HUNT;
            locked_o <= 1'b0;
          end
        end
        default: begin
          state    <= HUNT;
          locked_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
